decode_stage_p: RTL
===================

// Module: decode_stage_p
// PURPOSE
//  Parametrised Y86-64 decode stage: owns the D pipeline register (stall/bubble), the
//  architectural register file (2 read, 2 write ports) and the 5-source forwarding network.
//  Sits between fetch and the E pipeline register; derives srcA/srcB/dstE/dstM per icode
//  and flags load-use and ret hazards to pipeline control.
// PARAMETERS
//  XLEN     64   data/register width
//  NREGS    16   architectural registers; index width RW = $clog2(NREGS)
//  RSP_IDX  4    stack-pointer index used by push/pop/call/ret
//  RNONE    NREGS-1 (all ones)  "no register" encoding; never written, never forwarded
// PORTS
//  clk        in   1     clock
//  rst        in   1     asynchronous reset, active high
//  f_icode,f_ifun in 4 each  fetched instruction fields
//  f_rA,f_rB  in   RW    fetched register specifiers
//  f_valC,f_valP in XLEN immediate / incremented PC
//  f_stat     in   2     fetch status (AOK/HLT/ADR/INS)
//  D_stall,D_bubble in 1 pipeline control for the D register
//  e_dstE,M_dstM,M_dstE,W_dstM,W_dstE in RW  forwarding destinations
//  e_valE,m_valM,M_valE,W_valM,W_valE in XLEN forwarding values
//  E_icode    in   4     icode in E register (load-use detection)
//  E_dstM     in   RW    dstM in E register
//  d_icode,d_ifun out 4  pass-through of D register
//  d_valC     out  XLEN  pass-through; d_stat out 2
//  d_srcA,d_srcB,d_dstE,d_dstM out RW  decoded register ids
//  d_valA,d_valB out XLEN forwarded operands
//  load_use   out  1     E holds mrmovq/popq with E_dstM in {d_srcA,d_srcB}, E_dstM!=RNONE
//  ret_in_D   out  1     d_icode==RET
// BEHAVIOUR
//  - D register reset (async): bubble = icode NOP, ifun 0, rA=rB=RNONE, valC=valP=0, stat AOK.
//  - posedge: D_bubble -> load bubble (bubble wins over stall); else D_stall -> hold;
//    else load f_*. Latency fetch->d_* = 1 cycle; all d_* combinational from D register.
//  - Reset clears every register file entry to 0; rst mid-run discards in-flight D contents.
//  - RF write at posedge: W_dstE!=RNONE writes W_valE; W_dstM!=RNONE writes W_valM;
//    same index on both -> W_valM wins. Writes not gated by D_stall.
//  - srcA: rA for rrmov/rmmov/opq/push; RSP for pop/ret; else RNONE.
//    srcB: rB for opq/rmmov/mrmov; RSP for push/pop/call/ret; else RNONE.
//    dstE: rB for cmov(rrmov)/irmov/opq; RSP for push/pop/call/ret; else RNONE.
//    dstM: rA for mrmov/pop; else RNONE. Undefined icode -> all RNONE, vals 0.
//  - d_valA priority: call/jXX -> D_valP; then srcA match on e_dstE, M_dstM, M_dstE,
//    W_dstM, W_dstE (first wins); else RF[srcA]. d_valB same chain without the valP term.
//    srcX==RNONE -> value 0, no forwarding. RF read is combinational, pre-write.
//  - load_use/ret_in_D are combinational; stage never stalls itself.
// STRUCTURE
//  - Package y86_pkg: icode constants (HALT..POPQ), stat codes, RNONE, RSP_IDX defaults.
//  - Sub-module y86_regfile (#(XLEN,NREGS), 2 async reads, 2 sync writes, async clear).
//  - Decode/forward logic and D register stay in this module.
// TESTING
//  - rst high mid-run -> d_icode=NOP, d_dstE=d_dstM=RNONE, all RF reads 0 after release.
//  - irmovq $5,%rax then addq %rax,%rbx back-to-back -> d_valA=5 via e_valE forwarding.
//  - e_dstE=M_dstE=W_dstE=rcx (1,2,3) -> d_valA=1; drop e -> 2; drop M -> 3.
//  - E: mrmovq into %rdx, D: addq %rdx,%rsi -> load_use=1; no E match -> load_use=0.
//  - W_dstE=W_dstM=r8, valE=7, valM=9 -> next cycle RF[r8]=9.
//  - D_stall=1 with f_* changing -> d_* held; D_stall=D_bubble=1 -> bubble loaded.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and default register indices.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    localparam int NREGS_DEFAULT = 16;
    localparam int RSP_DEFAULT   = 4;
    localparam int RNONE_DEFAULT = NREGS_DEFAULT - 1;
endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational read ports, two synchronous write ports
// (M port wins on an index collision), whole array cleared by reset.
module y86_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 16,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RW-1:0]   ra_a,
    input  logic [RW-1:0]   ra_b,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b,
    input  logic            we_e,
    input  logic [RW-1:0]   wa_e,
    input  logic [XLEN-1:0] wd_e,
    input  logic            we_m,
    input  logic [RW-1:0]   wa_m,
    input  logic [XLEN-1:0] wd_m
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_m && wa_m == RW'(i))
                    regs[i] <= wd_m;
                else if (we_e && wa_e == RW'(i))
                    regs[i] <= wd_e;
            end
        end
    end

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];
endmodule

// File: rtl/decode_stage_p.sv
// Y86-64 decode stage: D pipeline register, register file, operand forwarding and
// load-use / ret hazard flags for pipeline control.
module decode_stage_p
    import y86_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NREGS   = NREGS_DEFAULT,
    parameter int RSP_IDX = RSP_DEFAULT,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      f_icode,
    input  logic [3:0]      f_ifun,
    input  logic [RW-1:0]   f_rA,
    input  logic [RW-1:0]   f_rB,
    input  logic [XLEN-1:0] f_valC,
    input  logic [XLEN-1:0] f_valP,
    input  logic [1:0]      f_stat,
    input  logic            D_stall,
    input  logic            D_bubble,
    input  logic [RW-1:0]   e_dstE,
    input  logic [RW-1:0]   M_dstM,
    input  logic [RW-1:0]   M_dstE,
    input  logic [RW-1:0]   W_dstM,
    input  logic [RW-1:0]   W_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic [XLEN-1:0] m_valM,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] W_valM,
    input  logic [XLEN-1:0] W_valE,
    input  logic [3:0]      E_icode,
    input  logic [RW-1:0]   E_dstM,
    output logic [3:0]      d_icode,
    output logic [3:0]      d_ifun,
    output logic [XLEN-1:0] d_valC,
    output logic [1:0]      d_stat,
    output logic [RW-1:0]   d_srcA,
    output logic [RW-1:0]   d_srcB,
    output logic [RW-1:0]   d_dstE,
    output logic [RW-1:0]   d_dstM,
    output logic [XLEN-1:0] d_valA,
    output logic [XLEN-1:0] d_valB,
    output logic            load_use,
    output logic            ret_in_D
);
    localparam logic [RW-1:0] RNONE = RW'(NREGS - 1);
    localparam logic [RW-1:0] RSP   = RW'(RSP_IDX);

    logic [3:0]      icode_reg, ifun_reg;
    logic [RW-1:0]   ra_reg, rb_reg;
    logic [XLEN-1:0] valc_reg, valp_reg;
    logic [1:0]      stat_reg;
    logic [XLEN-1:0] rf_a, rf_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!rst && D_bubble)) begin
            icode_reg <= I_NOP;
            ifun_reg  <= 4'h0;
            ra_reg    <= RNONE;
            rb_reg    <= RNONE;
            valc_reg  <= '0;
            valp_reg  <= '0;
            stat_reg  <= S_AOK;
        end else if (!D_stall) begin
            icode_reg <= f_icode;
            ifun_reg  <= f_ifun;
            ra_reg    <= f_rA;
            rb_reg    <= f_rB;
            valc_reg  <= f_valC;
            valp_reg  <= f_valP;
            stat_reg  <= f_stat;
        end
    end

    assign d_icode = icode_reg;
    assign d_ifun  = ifun_reg;
    assign d_valC  = valc_reg;
    assign d_stat  = stat_reg;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (icode_reg)
            I_RRMOVQ: begin d_srcA = ra_reg; d_dstE = rb_reg; end
            I_IRMOVQ: d_dstE = rb_reg;
            I_RMMOVQ: begin d_srcA = ra_reg; d_srcB = rb_reg; end
            I_MRMOVQ: begin d_srcB = rb_reg; d_dstM = ra_reg; end
            I_OPQ:    begin d_srcA = ra_reg; d_srcB = rb_reg; d_dstE = rb_reg; end
            I_CALL:   begin d_srcB = RSP; d_dstE = RSP; end
            I_RET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
            I_PUSHQ:  begin d_srcA = ra_reg; d_srcB = RSP; d_dstE = RSP; end
            I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = ra_reg; end
            default:  ;
        endcase
    end

    y86_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk  (clk),
        .rst  (rst),
        .ra_a (d_srcA),
        .ra_b (d_srcB),
        .rd_a (rf_a),
        .rd_b (rf_b),
        .we_e (W_dstE != RNONE),
        .wa_e (W_dstE),
        .wd_e (W_valE),
        .we_m (W_dstM != RNONE),
        .wa_m (W_dstM),
        .wd_m (W_valM)
    );

    // Youngest producer wins; a source of RNONE never matches and reads as zero.
    always_comb begin
        d_valA = '0;
        if (icode_reg == I_CALL || icode_reg == I_JXX) d_valA = valp_reg;
        else if (d_srcA == RNONE)                      d_valA = '0;
        else if (d_srcA == e_dstE)                     d_valA = e_valE;
        else if (d_srcA == M_dstM)                     d_valA = m_valM;
        else if (d_srcA == M_dstE)                     d_valA = M_valE;
        else if (d_srcA == W_dstM)                     d_valA = W_valM;
        else if (d_srcA == W_dstE)                     d_valA = W_valE;
        else                                           d_valA = rf_a;
    end

    always_comb begin
        d_valB = '0;
        if (d_srcB == RNONE)       d_valB = '0;
        else if (d_srcB == e_dstE) d_valB = e_valE;
        else if (d_srcB == M_dstM) d_valB = m_valM;
        else if (d_srcB == M_dstE) d_valB = M_valE;
        else if (d_srcB == W_dstM) d_valB = W_valM;
        else if (d_srcB == W_dstE) d_valB = W_valE;
        else                       d_valB = rf_b;
    end

    assign load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != RNONE)
                      && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign ret_in_D = (icode_reg == I_RET);
endmodule
